sap1_controller: RTL and testbench



---
 rtl/sap1_controller_if.sv | 32 +++
 rtl/sap1_controller.sv | 111 +++++++++++
 tb/tb_sap1_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sap1_controller_if.sv
// Control bus between the SAP-1 controller and its datapath: sequencing inputs,
// ring-state debug view and the per-cycle control word.
interface sap1_controller_if;
  // The datapath samples the control word on the rising edge that advances
  // the ring; run=0 holds the ring and zeroes the control word.
  logic       run;
  logic [3:0] opcode;
  logic [5:0] tstate;
  logic       CE;
  logic       CO;
  logic       MI;
  logic       RO;
  logic       II;
  logic       IO;
  logic       AI;
  logic       AO;
  logic       BI;
  logic       EO;
  logic       SU;
  logic       OI;
  logic       HLT;

  modport master (
    input  run, opcode,
    output tstate, CE, CO, MI, RO, II, IO, AI, AO, BI, EO, SU, OI, HLT
  );

  modport slave (
    output run, opcode,
    input  tstate, CE, CO, MI, RO, II, IO, AI, AO, BI, EO, SU, OI, HLT
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring with fixed fetch and
// opcode-decoded execute, plus a sticky halt left only through reset.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input logic               clk,
  input logic               reset,
  sap1_controller_if.master ctrl
);
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  logic [5:0] r_ring;
  logic       r_halted;
  logic [5:0] w_ring_next;
  logic       w_halted_next;
  logic       w_ring_ok;
  logic       w_active;
  logic       w_ce, w_co, w_mi, w_ro, w_ii, w_io;
  logic       w_ai, w_ao, w_bi, w_eo, w_su, w_oi;

  assign w_ring_ok = (r_ring != 6'd0) && ((r_ring & (r_ring - 6'd1)) == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ring   <= T1;
      r_halted <= 1'b0;
    end else begin
      r_ring   <= w_ring_next;
      r_halted <= w_halted_next;
    end
  end

  // A corrupted ring recovers to T1 even while run is low.
  always_comb begin
    w_ring_next   = r_ring;
    w_halted_next = r_halted;
    if (!r_halted) begin
      if (!w_ring_ok) begin
        w_ring_next = T1;
      end else if (ctrl.run) begin
        if (r_ring == T4 && ctrl.opcode == OP_HLT) begin
          w_ring_next   = 6'd0;
          w_halted_next = 1'b1;
        end else begin
          w_ring_next = {r_ring[4:0], r_ring[5]};
        end
      end
    end
  end

  assign w_active = !reset && ctrl.run && !r_halted;

  always_comb begin
    w_ce = 1'b0; w_co = 1'b0; w_mi = 1'b0; w_ro = 1'b0;
    w_ii = 1'b0; w_io = 1'b0; w_ai = 1'b0; w_ao = 1'b0;
    w_bi = 1'b0; w_eo = 1'b0; w_su = 1'b0; w_oi = 1'b0;
    if (w_active) begin
      case (r_ring)
        T1: begin w_co = 1'b1; w_mi = 1'b1; end
        T2: w_ce = 1'b1;
        T3: begin w_ro = 1'b1; w_ii = 1'b1; end
        T4: begin
          case (ctrl.opcode)
            OP_LDA, OP_ADD, OP_SUB: begin w_io = 1'b1; w_mi = 1'b1; end
            OP_OUT:                 begin w_ao = 1'b1; w_oi = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (ctrl.opcode)
            OP_LDA:         begin w_ro = 1'b1; w_ai = 1'b1; end
            OP_ADD, OP_SUB: begin w_ro = 1'b1; w_bi = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (ctrl.opcode)
            OP_ADD: begin w_eo = 1'b1; w_ai = 1'b1; end
            OP_SUB: begin w_eo = 1'b1; w_ai = 1'b1; w_su = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign ctrl.tstate = r_ring;
  assign ctrl.HLT    = r_halted && !reset;
  assign ctrl.CE     = w_ce;
  assign ctrl.CO     = w_co;
  assign ctrl.MI     = w_mi;
  assign ctrl.RO     = w_ro;
  assign ctrl.II     = w_ii;
  assign ctrl.IO     = w_io;
  assign ctrl.AI     = w_ai;
  assign ctrl.AO     = w_ao;
  assign ctrl.BI     = w_bi;
  assign ctrl.EO     = w_eo;
  assign ctrl.SU     = w_su;
  assign ctrl.OI     = w_oi;
endmodule

// File: tb/tb_sap1_controller.sv
// Bench for sap1_controller: directed scenarios plus random run/opcode/reset
// traffic, compared each cycle against a T-step/halt reference model.
module tb_sap1_controller;
  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic clk;
  logic rst;
  sap1_controller_if bus ();

  sap1_controller dut (
    .clk   (clk),
    .reset (rst),
    .ctrl  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          bad = 0;
  int          m_t = 1;
  logic        m_halted = 1'b0;
  logic        chk_en = 1'b0;
  logic [18:0] got;
  logic [18:0] exp;

  // {tstate, HLT, CE, CO, MI, RO, II, IO, AI, AO, BI, EO, SU, OI}
  function automatic logic [18:0] dut_word();
    return {bus.tstate, bus.HLT, bus.CE, bus.CO, bus.MI, bus.RO, bus.II,
            bus.IO, bus.AI, bus.AO, bus.BI, bus.EO, bus.SU, bus.OI};
  endfunction

  function automatic logic [18:0] model_word();
    logic ce, co, mi, ro, ii, io, ai, ao, bi, eo, su, oi;
    logic [5:0] ts;
    logic [3:0] op;
    op = bus.opcode;
    {ce, co, mi, ro, ii, io, ai, ao, bi, eo, su, oi} = 12'd0;
    ts = m_halted ? 6'd0 : (6'd1 << (m_t - 1));
    if (!rst && bus.run && !m_halted) begin
      case (m_t)
        1: begin co = 1'b1; mi = 1'b1; end
        2: ce = 1'b1;
        3: begin ro = 1'b1; ii = 1'b1; end
        4: if (op == LDA || op == ADD || op == SUB) begin io = 1'b1; mi = 1'b1; end
           else if (op == OUT) begin ao = 1'b1; oi = 1'b1; end
        5: if (op == LDA) begin ro = 1'b1; ai = 1'b1; end
           else if (op == ADD || op == SUB) begin ro = 1'b1; bi = 1'b1; end
        6: if (op == ADD) begin eo = 1'b1; ai = 1'b1; end
           else if (op == SUB) begin eo = 1'b1; ai = 1'b1; su = 1'b1; end
        default: ;
      endcase
    end
    return {ts, m_halted && !rst, ce, co, mi, ro, ii, io, ai, ao, bi, eo, su, oi};
  endfunction

  // Advance one clock, stepping the reference model with the inputs held across the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_t = 1;
      m_halted = 1'b0;
    end else if (!m_halted && bus.run) begin
      if (m_t == 4 && bus.opcode == HLT) m_halted = 1'b1;
      else m_t = (m_t % 6) + 1;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      checks++;
      if ($countones({bus.CO, bus.RO, bus.IO, bus.AO, bus.EO}) > 1) begin
        $display("FAIL bus_drivers t=%0t got=%b required at most one high", $time,
                 {bus.CO, bus.RO, bus.IO, bus.AO, bus.EO});
        bad++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b1;
    bus.opcode = ADD;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_en = 1'b1;
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, got, exp); bad++;
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL fetch cyc=%0d got=%h exp=%h", i, got, exp); bad++;
      end
      tick();
    end
  endtask

  task automatic test_opcodes();
    logic [3:0] ops [6];
    ops = '{ADD, SUB, OUT, LDA, 4'b0101, 4'(($urandom_range(10, 3)))};
    bus.run = 1'b1;
    foreach (ops[k]) begin
      for (int c = 0; c < 6; c++) begin
        bus.opcode = (m_t >= 4) ? ops[k] : 4'($urandom_range(15, 0));
        #1; got = dut_word(); exp = model_word(); checks++;
        if (got !== exp) begin
          $display("FAIL opcode op=%h T%0d got=%h exp=%h", ops[k], m_t, got, exp); bad++;
        end
        tick();
      end
    end
  endtask

  task automatic test_run_pause();
    bus.run = 1'b1;
    bus.opcode = OUT;
    for (int g = 0; g < 8 && m_t != 2; g++) begin
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL pause_align T%0d got=%h exp=%h", m_t, got, exp); bad++;
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      bus.run = (c >= 3) ? 1'b1 : 1'b0;
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL run_pause cyc=%0d got=%h exp=%h", c, got, exp); bad++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.run = 1'b1;
    bus.opcode = LDA;
    for (int g = 0; g < 8 && m_t != 5; g++) tick();
    for (int c = 0; c < 3; c++) begin
      rst = (c == 1) ? 1'b1 : 1'b0;
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, got, exp); bad++;
      end
      tick();
    end
  endtask

  task automatic test_halt();
    bus.run = 1'b1;
    for (int g = 0; g < 8 && m_t != 4; g++) begin
      bus.opcode = 4'($urandom_range(15, 0));
      tick();
    end
    bus.opcode = HLT;
    for (int c = 0; c < 22; c++) begin
      if (c > 1) bus.run = 1'($urandom_range(1, 0));
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL halt cyc=%0d got=%h exp=%h", c, got, exp); bad++;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.run = 1'b1;
    #1; got = dut_word(); exp = model_word(); checks++;
    if (got !== exp) begin
      $display("FAIL halt_exit got=%h exp=%h", got, exp); bad++;
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] pick [5];
    pick = '{LDA, ADD, SUB, OUT, HLT};
    for (int c = 0; c < 400; c++) begin
      bus.run = ($urandom_range(9, 0) != 0);
      rst = m_halted ? ($urandom_range(4, 0) == 0) : ($urandom_range(49, 0) == 0);
      if ($urandom_range(3, 0) == 0) bus.opcode = 4'($urandom_range(15, 0));
      else bus.opcode = pick[$urandom_range(3, 0) + (($urandom_range(7, 0) == 0) ? 1 : 0)];
      #1; got = dut_word(); exp = model_word(); checks++;
      if (got !== exp) begin
        $display("FAIL random cyc=%0d op=%h got=%h exp=%h", c, bus.opcode, got, exp); bad++;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.run = 1'b0;
    bus.opcode = 4'd0;
    test_reset();
    test_opcodes();
    test_run_pause();
    test_reset_mid();
    test_halt();
    test_random();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
